fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction fetch stage directly upstream of the decode ROM. Owns the PC, fetches
//   from the I-cache with a hold-until-resp handshake, and buffers fetched words in a
//   small FIFO. Presents {pc, instr} plus pre-split opcode/funct3/funct7 to decode.
//   Redirects from EX (branch taken, JAL, JALR) flush the FIFO and squash in-flight fetches.
// PARAMETERS
//   RESET_PC  32'h0000_0060  PC of first fetch after reset
//   DEPTH     2              fetch FIFO entries (power of 2, >=2)
// PORTS
//   clk             in   1   clock, all state updates on rising edge
//   rst_n           in   1   asynchronous active-low reset
//   icache_read     out  1   fetch request; held high until icache_resp
//   icache_address  out  32  fetch address; stable while icache_read high
//   icache_resp     in   1   one-cycle pulse: icache_rdata valid
//   icache_rdata    in   32  fetched instruction word
//   redirect        in   1   EX redirect strobe (taken branch / jal / jalr)
//   redirect_pc     in   32  redirect target; bits [1:0] forced to 0 internally
//   stall           in   1   decode cannot accept this cycle
//   id_valid        out  1   FIFO head valid
//   id_pc           out  32  PC of FIFO head
//   id_instr        out  32  instruction word of FIFO head
//   id_opcode       out  7   id_instr[6:0] (cast to rv32i_opcode by decode)
//   id_funct3       out  3   id_instr[14:12]
//   id_funct7       out  7   id_instr[31:25]
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, FIFO count=0, squash target clear;
//     icache_read=0, id_valid=0, id_pc/id_instr/id_opcode/id_funct3/id_funct7 = 0.
//   FSM states: IDLE, REQ, SQUASH. icache_read=1 in REQ and SQUASH; icache_address=pc.
//     IDLE  : redirect -> pc<=redirect_pc, REQ. Else if count<DEPTH -> REQ. Else stay.
//     REQ   : resp & !redirect -> push {pc,rdata}, pc<=pc+4; REQ if count_next<DEPTH
//             else IDLE. resp & redirect -> drop rdata, pc<=redirect_pc, REQ.
//             !resp & redirect -> pc<=redirect_pc, SQUASH (address must stay
//             stable, so the old address is held in a separate latched register).
//     SQUASH: icache_address = latched killed address. resp -> discard rdata, REQ.
//             redirect (any) -> overwrite pending pc with newest redirect_pc.
//   Latency: resp at edge N -> id_valid=1 at N+1 (FIFO empty case); min 2 cycles
//     from request issue to id_valid, no combinational cache-to-decode path.
//   FIFO: pop when id_valid & !stall & !redirect. Push only from REQ as above.
//     Requests gated so push never overflows; push+pop same cycle legal, count unchanged.
//   Redirect priority: flushes FIFO (count<=0) the same edge; pop ignored;
//     id_valid=0 next cycle. Stale (squashed) words never appear at id_*.
//   id_* outputs are FIFO-head registers/decodes; all id_* fields = 0 when id_valid=0.
//   PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
//   Reset asserted mid-request: immediate return to reset values; any later
//     icache_resp while in IDLE after reset is ignored.
//   icache_resp outside REQ/SQUASH is ignored (protocol violation, no state change).
// TESTING
//   1 Reset release, cache resp 1 cycle after each request, stall=0 -> id_pc
//     0x60,0x64,0x68...; id_opcode=instr[6:0] of each word; no bubbles after first.
//   2 stall=1 held, DEPTH=2 -> exactly 2 pushes, icache_read=0 after 2nd resp;
//     release stall -> 0x60,0x64 drain in order, fetching resumes at 0x68.
//   3 redirect to 0x200 while REQ at 0x64 awaits resp (3-cycle miss) -> SQUASH,
//     address held 0x64 until resp, that word dropped; next id_valid has id_pc=0x200.
//   4 redirect to 0x300 coincident with resp -> rdata dropped, FIFO empty,
//     next request address 0x300, no SQUASH state visited.
//   5 redirect_pc=0x0000_0103 -> fetch address 0x100; pc at 0xFFFF_FFFC with
//     resp -> next icache_address 0x0000_0000.
//   6 rst_n low mid-SQUASH with FIFO full -> same cycle icache_read=0, id_valid=0;
//     after release, first fetch at RESET_PC, stray resp ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues hold-until-resp I-cache reads and
// buffers fetched words in a small FIFO in front of decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        icache_read,
    output logic [31:0] icache_address,
    input  logic        icache_resp,
    input  logic [31:0] icache_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, SQUASH} state_t;

    state_t        state, state_next;
    logic [31:0]   pc, pc_next;
    logic [31:0]   squash_addr, squash_addr_next;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic          push, pop;
    logic [31:0]   target;

    assign target         = {redirect_pc[31:2], 2'b00};
    assign id_valid       = (count != '0);
    assign pop            = id_valid && !stall && !redirect;
    assign push           = (state == REQ) && icache_resp && !redirect;
    assign icache_read    = (state != IDLE);
    // A killed request keeps its original address on the bus until the cache answers.
    assign icache_address = (state == SQUASH) ? squash_addr : pc;

    always_comb begin
        count_next = count;
        if (redirect)
            count_next = '0;
        else
            count_next = count + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        squash_addr_next = squash_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = REQ;
                end else if (count < CW'(DEPTH)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (icache_resp && !redirect) begin
                    pc_next    = pc + 32'd4;
                    state_next = (count_next < CW'(DEPTH)) ? REQ : IDLE;
                end else if (icache_resp) begin
                    pc_next = target;
                end else if (redirect) begin
                    squash_addr_next = pc;
                    pc_next          = target;
                    state_next       = SQUASH;
                end
            end
            SQUASH: begin
                if (redirect)
                    pc_next = target;
                if (icache_resp)
                    state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            squash_addr <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            squash_addr <= squash_addr_next;
            count       <= count_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= icache_rdata;
        end
    end

    // Head fields read as zero whenever the FIFO is empty.
    assign id_pc     = id_valid ? fifo_pc[rd_ptr]    : '0;
    assign id_instr  = id_valid ? fifo_instr[rd_ptr] : '0;
    assign id_opcode = id_instr[6:0];
    assign id_funct3 = id_instr[14:12];
    assign id_funct7 = id_instr[31:25];
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cache responder, a queue-based reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0060;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        icache_read;
    logic [31:0] icache_address;
    logic        icache_resp = 1'b0;
    logic [31:0] icache_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;
    logic [6:0]  id_opcode, id_funct7;
    logic [2:0]  id_funct3;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cache contents: every address returns a distinct, easily hand-computed word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8], ~a[7:0], a[7:0]};
    endfunction

    // Reference model: queue of buffered {pc,instr}, next fetch pc, request/kill flags.
    logic [63:0] q[$];
    logic [31:0] m_fpc, m_kaddr, m_tgt;
    bit          m_req, m_kill, m_pop;
    int          m_sz;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_fpc  = RESET_PC;
            m_req  = 1'b0;
            m_kill = 1'b0;
            chk("m_rst_read", {31'd0, icache_read}, 32'd0);
            chk("m_rst_valid", {31'd0, id_valid}, 32'd0);
            chk("m_rst_id_pc", id_pc, 32'd0);
            chk("m_rst_id_instr", id_instr, 32'd0);
        end else begin
            chk("m_read", {31'd0, icache_read}, {31'd0, m_req});
            if (m_req)
                chk("m_addr", icache_address, m_kill ? m_kaddr : m_fpc);
            chk("m_valid", {31'd0, id_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                chk("m_id_pc", id_pc, q[0][63:32]);
                chk("m_id_instr", id_instr, q[0][31:0]);
                chk("m_opcode", {25'd0, id_opcode}, {25'd0, q[0][6:0]});
                chk("m_funct3", {29'd0, id_funct3}, {29'd0, q[0][14:12]});
                chk("m_funct7", {25'd0, id_funct7}, {25'd0, q[0][31:25]});
            end else begin
                chk("m_id_pc_zero", id_pc, 32'd0);
                chk("m_id_fields_zero", {id_instr[31:0] | {15'd0, id_opcode, id_funct3, id_funct7}}, 32'd0);
            end

            m_sz  = q.size();
            m_tgt = {redirect_pc[31:2], 2'b00};
            m_pop = (m_sz > 0) && !stall && !redirect;
            if (redirect)
                q.delete();
            else if (m_pop)
                void'(q.pop_front());
            if (!m_req) begin
                if (redirect) begin
                    m_fpc = m_tgt;
                    m_req = 1'b1;
                end else if (m_sz < DEPTH) begin
                    m_req = 1'b1;
                end
            end else if (!m_kill) begin
                if (icache_resp && !redirect) begin
                    q.push_back({m_fpc, mem_word(m_fpc)});
                    m_fpc = m_fpc + 32'd4;
                    m_req = (q.size() < DEPTH);
                end else if (icache_resp) begin
                    m_fpc = m_tgt;
                end else if (redirect) begin
                    m_kill  = 1'b1;
                    m_kaddr = m_fpc;
                    m_fpc   = m_tgt;
                end
            end else begin
                if (redirect)
                    m_fpc = m_tgt;
                if (icache_resp)
                    m_kill = 1'b0;
            end
        end
    end

    // Responder: answers a held request after lat waiting cycles.
    int lat = 0;
    int wait_cnt = 0;
    bit force_resp = 1'b0;

    task automatic step();
        @(posedge clk);
        #2;
        if (icache_read) begin
            if (wait_cnt >= lat) begin
                icache_resp  = 1'b1;
                icache_rdata = mem_word(icache_address);
                wait_cnt     = 0;
            end else begin
                icache_resp  = 1'b0;
                icache_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            wait_cnt     = 0;
            icache_resp  = force_resp;
            icache_rdata = force_resp ? 32'hBAD0_0BAD : 32'hDEAD_BEEF;
        end
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        chk({name, "_async_read"}, {31'd0, icache_read}, 32'd0);
        chk({name, "_async_valid"}, {31'd0, id_valid}, 32'd0);
        chk({name, "_async_id_pc"}, id_pc, 32'd0);
        wait_cnt = 0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a, input int budget);
        int n = 0;
        while (!(icache_read && icache_address == a) && n < budget) begin
            step();
            n++;
        end
        chk(name, {31'd0, icache_read && icache_address == a}, 32'd1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!id_valid && n < budget) begin
            step();
            n++;
        end
        chk(name, {31'd0, id_valid}, 32'd1);
    endtask

    initial begin
        step();
        step();
        chk("reset_read", {31'd0, icache_read}, 32'd0);
        chk("reset_valid", {31'd0, id_valid}, 32'd0);
        chk("reset_id_pc", id_pc, 32'd0);
        chk("reset_opcode", {25'd0, id_opcode}, 32'd0);
        rst_n = 1'b1;

        // Back-to-back fetch with single-cycle cache
        step();
        chk("t1_first_read", {31'd0, icache_read}, 32'd1);
        chk("t1_first_addr", icache_address, 32'h60);
        step();
        chk("t1_valid", {31'd0, id_valid}, 32'd1);
        chk("t1_pc0", id_pc, 32'h60);
        chk("t1_instr0", id_instr, 32'h3A00_9F60);
        chk("t1_opcode0", {25'd0, id_opcode}, 32'h60);
        chk("t1_funct3_0", {29'd0, id_funct3}, 32'd1);
        chk("t1_funct7_0", {25'd0, id_funct7}, 32'h1D);
        step();
        chk("t1_pc1", id_pc, 32'h64);
        step();
        chk("t1_pc2", id_pc, 32'h68);
        repeat (8) step();

        // Stall fills the FIFO, then drains in order
        do_reset("t2");
        stall = 1'b1;
        repeat (3) step();
        chk("t2_idle_read", {31'd0, icache_read}, 32'd0);
        chk("t2_head_pc", id_pc, 32'h60);
        repeat (4) step();
        chk("t2_hold_read", {31'd0, icache_read}, 32'd0);
        chk("t2_hold_head", id_pc, 32'h60);
        stall = 1'b0;
        step();
        chk("t2_drain_pc", id_pc, 32'h64);
        chk("t2_drain_read", {31'd0, icache_read}, 32'd0);
        step();
        chk("t2_resume_read", {31'd0, icache_read}, 32'd1);
        chk("t2_resume_addr", icache_address, 32'h68);
        repeat (6) step();

        // Redirect during a miss squashes the outstanding fetch
        do_reset("t3");
        lat = 3;
        wait_addr("t3_reach_64", 32'h64, 30);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        chk("t3_squash_read", {31'd0, icache_read}, 32'd1);
        chk("t3_squash_addr", icache_address, 32'h64);
        step();
        chk("t3_squash_addr2", icache_address, 32'h64);
        wait_addr("t3_reach_200", 32'h200, 20);
        wait_valid("t3_valid", 30);
        chk("t3_pc", id_pc, 32'h200);
        chk("t3_instr", id_instr, 32'h5A02_FF00);
        chk("t3_opcode", {25'd0, id_opcode}, 32'h00);
        chk("t3_funct3", {29'd0, id_funct3}, 32'd7);
        chk("t3_funct7", {25'd0, id_funct7}, 32'h2D);
        lat = 0;
        repeat (4) step();

        // Redirect coincident with a response
        do_reset("t4");
        wait_valid("t4_valid", 10);
        chk("t4_resp_coincident", {31'd0, icache_resp}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        chk("t4_read", {31'd0, icache_read}, 32'd1);
        chk("t4_addr", icache_address, 32'h300);
        chk("t4_flushed", {31'd0, id_valid}, 32'd0);
        step();
        chk("t4_pc", id_pc, 32'h300);

        // Misaligned target and PC wrap
        chk("t5_resp_a", {31'd0, icache_resp}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        chk("t5_align_addr", icache_address, 32'h100);
        step();
        chk("t5_align_pc", id_pc, 32'h100);
        chk("t5_resp_b", {31'd0, icache_resp}, 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("t5_top_addr", icache_address, 32'hFFFF_FFFC);
        step();
        chk("t5_wrap_addr", icache_address, 32'h0);
        chk("t5_top_pc", id_pc, 32'hFFFF_FFFC);
        step();
        chk("t5_wrap_pc", id_pc, 32'h0);

        // Reset with a full FIFO, then mid-squash with a stray response afterwards
        stall = 1'b1;
        repeat (4) step();
        chk("t6_full_read", {31'd0, icache_read}, 32'd0);
        chk("t6_full_valid", {31'd0, id_valid}, 32'd1);
        stall = 1'b0;
        do_reset("t6a");
        lat = 4;
        wait_addr("t6_reach_64", 32'h64, 30);
        redirect = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        chk("t6_in_squash", icache_address, 32'h64);
        force_resp = 1'b1;
        lat = 0;
        do_reset("t6b");
        step();
        force_resp = 1'b0;
        chk("t6_restart_read", {31'd0, icache_read}, 32'd1);
        chk("t6_restart_addr", icache_address, RESET_PC);
        wait_valid("t6_valid", 10);
        chk("t6_first_pc", id_pc, RESET_PC);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
